adder_pipe_arbiter: RTL and testbench

- Shares one adder_pipe_64bit instance between NUM_REQ requesters.
- Round-robin arbitration issues at most one addition per cycle.
- A requester ID tag travels in a shadow pipeline matched to the adder latency, so each result returns with its requester ID.
- Sits between client blocks and the adder; drives the adder's i_en/adda/addb and consumes its result/o_en.

---
 rtl/adder_pipe_arbiter_if.sv | 25 ++
 rtl/adder_pipe_arbiter.sv | 131 +++++++++++++
 tb/tb_adder_pipe_arbiter.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_pipe_arbiter_if.sv
// Client-side bus of the shared-adder arbiter: per-requester operands and
// grants in, tagged sums out.
interface adder_pipe_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 2
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          rsp_valid;
    logic [ID_WIDTH-1:0]           rsp_id;
    logic [DATA_WIDTH:0]           rsp_data;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/adder_pipe_arbiter.sv
// Round-robin front end sharing one pipelined adder between NUM_REQ clients;
// a shadow tag pipeline returns each sum with the id of its requester.
module adder_pipe_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int LATENCY    = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_enable,
    adder_pipe_arbiter_if.slave   req_if,
    output logic                  add_en,
    output logic [DATA_WIDTH-1:0] add_a,
    output logic [DATA_WIDTH-1:0] add_b,
    input  logic [DATA_WIDTH:0]   add_result,
    input  logic                  add_o_en,
    output logic                  busy,
    output logic                  err_tag
);

    typedef struct packed {
        logic                hit;
        logic [ID_WIDTH-1:0] id;
    } pick_t;

    // First requester with valid set, searching upward from last+1 with wrap.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] vld,
                                      input logic [ID_WIDTH-1:0] last);
        pick_t               p;
        logic [ID_WIDTH-1:0] idx;
        p = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_WIDTH'((int'(last) + k) % NUM_REQ);
            if (!p.hit && vld[idx]) begin
                p.hit = 1'b1;
                p.id  = idx;
            end
        end
        return p;
    endfunction

    logic [ID_WIDTH-1:0] last_granted;
    pick_t               pick_p0;
    logic [NUM_REQ-1:0]  grant_p0;

    logic [LATENCY-1:0]  tag_vld_p;
    logic [ID_WIDTH-1:0] tag_id_p [LATENCY];
    logic                tail_vld;

    logic                rsp_vld_p;
    logic [ID_WIDTH-1:0] rsp_id_p;
    logic [DATA_WIDTH:0] rsp_data_p;

    // ---- stage p0: arbitration and issue (combinational) ----
    always_comb begin
        pick_p0  = rr_pick(req_if.req_valid, last_granted);
        grant_p0 = '0;
        if (cfg_enable && pick_p0.hit) begin
            grant_p0[pick_p0.id] = 1'b1;
        end
    end

    assign req_if.req_ready = grant_p0;
    assign add_en           = |(req_if.req_valid & grant_p0);

    always_comb begin
        add_a = '0;
        add_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (add_en && (pick_p0.id == ID_WIDTH'(i))) begin
                add_a = req_if.req_a[i*DATA_WIDTH +: DATA_WIDTH];
                add_b = req_if.req_b[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_granted <= ID_WIDTH'(NUM_REQ - 1);
        end else if (add_en) begin
            last_granted <= pick_p0.id;
        end
    end

    // ---- tag pipeline: LATENCY stages shadowing the adder ----
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld_p <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                tag_id_p[s] <= '0;
            end
        end else begin
            tag_vld_p[0] <= add_en;
            tag_id_p[0]  <= pick_p0.id;
            for (int s = 1; s < LATENCY; s++) begin
                tag_vld_p[s] <= tag_vld_p[s-1];
                tag_id_p[s]  <= tag_id_p[s-1];
            end
        end
    end

    assign tail_vld = tag_vld_p[LATENCY-1];

    // ---- response stage: pair tail tag with adder output ----
    // A result without a matching tag (e.g. after a reset mid-flight) is
    // dropped and flagged; the flag stays up until the next reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_vld_p  <= 1'b0;
            rsp_id_p   <= '0;
            rsp_data_p <= '0;
            err_tag    <= 1'b0;
        end else begin
            rsp_vld_p <= tail_vld & add_o_en;
            if (tail_vld && add_o_en) begin
                rsp_id_p   <= tag_id_p[LATENCY-1];
                rsp_data_p <= add_result;
            end
            if (tail_vld ^ add_o_en) begin
                err_tag <= 1'b1;
            end
        end
    end

    assign req_if.rsp_valid = rsp_vld_p;
    assign req_if.rsp_id    = rsp_id_p;
    assign req_if.rsp_data  = rsp_data_p;
    assign busy             = (|tag_vld_p) | rsp_vld_p;

endmodule

// File: tb/tb_adder_pipe_arbiter.sv
// Directed bench for adder_pipe_arbiter with a behavioural un-resettable
// LATENCY-deep adder standing in for adder_pipe_64bit.
module tb_adder_pipe_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 64;
    localparam int LAT  = 4;
    localparam int IDW  = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           cfg_enable;
    logic           add_en;
    logic [DW-1:0]  add_a;
    logic [DW-1:0]  add_b;
    logic [DW:0]    add_result;
    logic           add_o_en;
    logic           busy;
    logic           err_tag;

    logic [DW-1:0]  op_a [NREQ];
    logic [DW-1:0]  op_b [NREQ];

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int t0;
    int base;

    logic [IDW-1:0] log_id   [$];
    logic [DW:0]    log_data [$];
    int             log_cyc  [$];

    adder_pipe_arbiter_if #(.NUM_REQ(NREQ), .DATA_WIDTH(DW), .ID_WIDTH(IDW)) bus ();

    adder_pipe_arbiter #(
        .NUM_REQ(NREQ), .DATA_WIDTH(DW), .LATENCY(LAT), .ID_WIDTH(IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_enable(cfg_enable),
        .req_if    (bus.slave),
        .add_en    (add_en),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_result(add_result),
        .add_o_en  (add_o_en),
        .busy      (busy),
        .err_tag   (err_tag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Adder model: never reset, like the real pipeline.
    logic [LAT-1:0] ad_en_p;
    logic [DW:0]    ad_sum_p [LAT];
    always @(posedge clk) begin
        ad_en_p[0]  <= add_en;
        ad_sum_p[0] <= {1'b0, add_a} + {1'b0, add_b};
        for (int s = 1; s < LAT; s++) begin
            ad_en_p[s]  <= ad_en_p[s-1];
            ad_sum_p[s] <= ad_sum_p[s-1];
        end
    end
    assign add_o_en   = ad_en_p[LAT-1];
    assign add_result = ad_sum_p[LAT-1];

    always_comb begin
        bus.req_a = '0;
        bus.req_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i*DW +: DW] = op_a[i];
            bus.req_b[i*DW +: DW] = op_b[i];
        end
    end

    always @(negedge clk) begin
        if (bus.rsp_valid === 1'b1) begin
            log_id.push_back(bus.rsp_id);
            log_data.push_back(bus.rsp_data);
            log_cyc.push_back(cyc);
        end
    end

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        cfg_enable    = 1'b1;
        bus.req_valid = '0;
        repeat (LAT + 2) tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        check_val(tag, 128'(busy), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        rst           = 1'b1;
        cfg_enable    = 1'b1;
        bus.req_valid = '0;
        do_reset();

        // Reset state
        check_val("rst_rsp_valid", 128'(bus.rsp_valid), 0);
        check_val("rst_rsp_id",    128'(bus.rsp_id),    0);
        check_val("rst_rsp_data",  128'(bus.rsp_data),  0);
        check_val("rst_err_tag",   128'(err_tag),       0);
        check_val("rst_busy",      128'(busy),          0);
        check_val("rst_ready",     128'(bus.req_ready), 0);

        // Single request with full carry-out
        op_a[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        op_b[0] = 64'h1;
        bus.req_valid = 4'b0001;
        #1;
        check_val("t1_ready", 128'(bus.req_ready), 128'h1);
        check_val("t1_add_en", 128'(add_en), 128'h1);
        check_val("t1_add_a", 128'(add_a), 128'hFFFF_FFFF_FFFF_FFFF);
        check_val("t1_add_b", 128'(add_b), 128'h1);
        tick();
        bus.req_valid = '0;
        #1;
        check_val("t1_add_a_idle", 128'(add_a), 0);
        repeat (LAT - 1) tick();
        check_val("t1_early", 128'(bus.rsp_valid), 0);
        tick();
        check_val("t1_rsp_valid", 128'(bus.rsp_valid), 1);
        check_val("t1_rsp_id",    128'(bus.rsp_id),    0);
        check_val("t1_rsp_data",  128'(bus.rsp_data),  128'h1_0000_0000_0000_0000);
        check_val("t1_busy",      128'(busy),          1);
        tick();
        check_val("t1_rsp_drop",  128'(bus.rsp_valid), 0);
        check_val("t1_data_hold", 128'(bus.rsp_data),  128'h1_0000_0000_0000_0000);
        check_val("t1_idle",      128'(busy),          0);

        // All four continuously valid: rotation 0,1,2,3,0,...
        do_reset();
        base = log_id.size();
        op_a[0] = 64'd0; op_a[1] = 64'd1; op_a[2] = 64'd2; op_a[3] = 64'd3;
        op_b[0] = 64'd100; op_b[1] = 64'd100; op_b[2] = 64'd100; op_b[3] = 64'd100;
        bus.req_valid = 4'hF;
        t0 = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (k == 0) t0 = cyc;
            check_val("t2_ready", 128'(bus.req_ready), 128'(1) << (k % 4));
            tick();
        end
        bus.req_valid = '0;
        wait_idle("t2_drain");
        check_val("t2_count", 128'(log_id.size() - base), 128'(8));
        for (int k = 0; k < 8; k++) begin
            check_val("t2_id",   128'(log_id[base+k]),   128'(k % 4));
            check_val("t2_data", 128'(log_data[base+k]), 128'(100 + k % 4));
            check_val("t2_cyc",  128'(log_cyc[base+k]),  128'(t0 + LAT + 1 + k));
        end

        // Fairness: req2 held, req1 pulses once
        do_reset();
        base = log_id.size();
        op_a[2] = 64'd7; op_b[2] = 64'd8;
        op_a[1] = 64'd1; op_b[1] = 64'd2;
        bus.req_valid = 4'b0100;
        #1 check_val("t3_g0", 128'(bus.req_ready), 128'h4);
        tick();
        bus.req_valid = 4'b0110;
        #1 check_val("t3_g1", 128'(bus.req_ready), 128'h2);
        tick();
        bus.req_valid = 4'b0100;
        #1 check_val("t3_g2", 128'(bus.req_ready), 128'h4);
        tick();
        bus.req_valid = '0;
        wait_idle("t3_drain");
        check_val("t3_count", 128'(log_id.size() - base), 128'(3));
        check_val("t3_id0", 128'(log_id[base]),     128'(2));
        check_val("t3_id1", 128'(log_id[base+1]),   128'(1));
        check_val("t3_id2", 128'(log_id[base+2]),   128'(2));
        check_val("t3_d1",  128'(log_data[base+1]), 128'(3));
        check_val("t3_d2",  128'(log_data[base+2]), 128'(15));

        // cfg_enable dropped after two issues
        do_reset();
        base = log_id.size();
        op_a[0] = 64'd11; op_b[0] = 64'd1;
        op_a[3] = 64'd20; op_b[3] = 64'd2;
        bus.req_valid = 4'b1001;
        #1;
        t0 = cyc;
        check_val("t4_g0", 128'(bus.req_ready), 128'h1);
        tick();
        #1 check_val("t4_g1", 128'(bus.req_ready), 128'h8);
        tick();
        cfg_enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_val("t4_off_ready", 128'(bus.req_ready), 0);
            check_val("t4_off_en",    128'(add_en),        0);
            tick();
        end
        bus.req_valid = '0;
        check_val("t4_at_cyc",   128'(cyc),           128'(t0 + LAT + 1));
        check_val("t4_r0_valid", 128'(bus.rsp_valid), 1);
        check_val("t4_r0_id",    128'(bus.rsp_id),    0);
        check_val("t4_r0_data",  128'(bus.rsp_data),  128'(12));
        tick();
        check_val("t4_r1_valid", 128'(bus.rsp_valid), 1);
        check_val("t4_r1_id",    128'(bus.rsp_id),    128'(3));
        check_val("t4_r1_data",  128'(bus.rsp_data),  128'(22));
        check_val("t4_busy_last", 128'(busy),         1);
        tick();
        check_val("t4_busy_fall", 128'(busy),          0);
        check_val("t4_rsp_off",   128'(bus.rsp_valid), 0);
        cfg_enable = 1'b1;

        // Reset two cycles after an issue: stray adder result flags err_tag
        do_reset();
        base = log_id.size();
        op_a[1] = 64'd5; op_b[1] = 64'd6;
        bus.req_valid = 4'b0010;
        #1 check_val("t5_issue", 128'(add_en), 1);
        tick();
        bus.req_valid = '0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("t5_rst_valid", 128'(bus.rsp_valid), 0);
        check_val("t5_rst_busy",  128'(busy),          0);
        check_val("t5_rst_err",   128'(err_tag),       0);
        tick();
        check_val("t5_stray_oen", 128'(add_o_en),      1);
        tick();
        check_val("t5_err_set",   128'(err_tag),       1);
        check_val("t5_no_rsp",    128'(bus.rsp_valid), 0);
        repeat (3) tick();
        check_val("t5_err_sticky", 128'(err_tag),      1);
        check_val("t5_no_log",    128'(log_id.size() - base), 0);
        do_reset();
        check_val("t5_err_clear", 128'(err_tag),       0);

        // Carry propagation across 16-bit boundaries, mixed requesters
        base = log_id.size();
        op_a[1] = 64'h0000_FFFF_0000_FFFF; op_b[1] = 64'h0000_0001_0000_0001;
        op_a[2] = 64'hFFFF_FFFF_FFFF_FFFF; op_b[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        op_a[3] = 64'd10;                  op_b[3] = 64'd20;
        bus.req_valid = 4'b1110;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_val("t6_ready", 128'(bus.req_ready), (k == 0) ? 128'h2 : (k == 1) ? 128'h4 : 128'h8);
            tick();
        end
        bus.req_valid = '0;
        wait_idle("t6_drain");
        check_val("t6_count", 128'(log_id.size() - base), 128'(3));
        check_val("t6_id0",   128'(log_id[base]),     128'(1));
        check_val("t6_d0",    128'(log_data[base]),   128'h0_0001_0000_0001_0000);
        check_val("t6_id1",   128'(log_id[base+1]),   128'(2));
        check_val("t6_d1",    128'(log_data[base+1]), 128'h1_FFFF_FFFF_FFFF_FFFE);
        check_val("t6_id2",   128'(log_id[base+2]),   128'(3));
        check_val("t6_d2",    128'(log_data[base+2]), 128'(30));
        check_val("t6_err",   128'(err_tag),          0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
